riscv_mem_req: RTL

Memory-request stage between EX and the write-back stage.
- Registers EX load/store information and issues aligned data-memory requests on a req/gnt bus.
- Generates byte enables and replicated store data, and detects misalignment.
- Tracks outstanding (granted, unacknowledged) transactions.
- Feeds PC, address and misaligned flag to write-back, which consumes dmem_ack_i/dmem_err_i.

---
 rtl/riscv_mem_req.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/riscv_mem_req.sv
// ---------------------------------------------------------------------------
// riscv_mem_req
// Memory-request stage sitting between EX and write-back. It registers the EX
// load/store, issues a word-aligned request on a req/gnt data bus (with byte
// enables and lane-replicated store data), flags misaligned accesses, and
// keeps a count of granted but not yet acknowledged transactions.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   ex_*_i                  EX instruction: valid, pc, load/store, size, address, store data
//   ex_flush_i              kill stage content and any ungranted request
//   wb_stall_i              write-back is stalled
//   mem_stall_o             EX must hold its instruction
//   mem_valid_o/pc_o/memadr_o/misaligned_o   registered stage content for write-back
//   dmem_req_o/we_o/adr_o/be_o/d_o           data-memory request outputs
//   dmem_gnt_i/ack_i/err_i                   data-memory handshake inputs
//   outstanding_o           number of granted, unacknowledged transactions
// ---------------------------------------------------------------------------
module riscv_mem_req #(
  parameter int              XLEN    = 32,
  parameter int              DEPTH   = 2,
  parameter logic [XLEN-1:0] PC_INIT = 'h200
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ex_valid_i,
  input  logic [XLEN-1:0]   ex_pc_i,
  input  logic              ex_load_i,
  input  logic              ex_store_i,
  input  logic [1:0]        ex_size_i,
  input  logic [XLEN-1:0]   ex_adr_i,
  input  logic [XLEN-1:0]   ex_d_i,
  input  logic              ex_flush_i,
  input  logic              wb_stall_i,
  output logic              mem_stall_o,
  output logic              mem_valid_o,
  output logic [XLEN-1:0]   mem_pc_o,
  output logic [XLEN-1:0]   mem_memadr_o,
  output logic              mem_misaligned_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [XLEN-1:0]   dmem_adr_o,
  output logic [XLEN/8-1:0] dmem_be_o,
  output logic [XLEN-1:0]   dmem_d_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_ack_i,
  input  logic              dmem_err_i,
  output logic [2:0]        outstanding_o
);

  localparam int         BW      = XLEN / 8;
  localparam logic [3:0] DEPTH_W = 4'(DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] adr_q;
  logic            mis_q;
  logic            we_q;
  logic [BW-1:0]   be_q;
  logic [XLEN-1:0] d_q;
  logic [2:0]      cnt_q, cnt_d;

  logic            mem;
  logic            misaligned;
  logic [BW-1:0]   be;
  logic [XLEN-1:0] data;
  logic            inc, dec;
  logic            space;
  logic            adv, capture;

  // Size decode: misalignment, byte lanes and lane-replicated store data.
  always_comb begin
    misaligned = 1'b0;
    be         = '0;
    data       = ex_d_i;
    case (ex_size_i)
      2'b00: begin
        be   = 4'b0001 << ex_adr_i[1:0];
        data = {4{ex_d_i[7:0]}};
      end
      2'b01: begin
        misaligned = ex_adr_i[0];
        be         = 4'b0011 << ex_adr_i[1:0];
        data       = {2{ex_d_i[15:0]}};
      end
      2'b10: begin
        misaligned = |ex_adr_i[1:0];
        be         = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Load+store together is treated as a store, so ex_store_i alone selects we.
  assign mem = ex_valid_i & (ex_load_i | ex_store_i);

  // A grant and a response in the same cycle cancel out; responses with
  // nothing outstanding (e.g. after a reset) are ignored.
  assign inc   = (state_q == REQ) & dmem_gnt_i;
  assign dec   = (dmem_ack_i | dmem_err_i) & (cnt_q != 3'd0);
  assign cnt_d = cnt_q + {2'b00, inc} - {2'b00, dec};
  assign space = ({1'b0, cnt_d} < DEPTH_W);

  // The stage may move only if write-back takes its content and no request
  // is still waiting for a grant.
  assign adv     = ~wb_stall_i & ~((state_q == REQ) & ~dmem_gnt_i);
  assign capture = adv & (~mem | space);

  // Next FSM state: flush wins, then capture, then a bubble, else hold.
  always_comb begin
    state_d = state_q;
    if (ex_flush_i) begin
      state_d = IDLE;
    end else if (capture) begin
      state_d = (mem & ~misaligned) ? REQ : IDLE;
    end else if (adv) begin
      state_d = IDLE;
    end
  end

  // Outstanding-transaction counter runs every cycle, including flush cycles,
  // so a grant coinciding with a flush is still tracked.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Stage registers. Request fields only change on capture, which keeps them
  // stable while a request waits for its grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      pc_q    <= PC_INIT;
      adr_q   <= '0;
      mis_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      if (ex_flush_i) begin
        valid_q <= 1'b0;
      end else if (capture) begin
        valid_q <= ex_valid_i;
        pc_q    <= ex_pc_i;
        adr_q   <= ex_adr_i;
        mis_q   <= mem & misaligned;
        we_q    <= ex_store_i;
        be_q    <= be;
        d_q     <= data;
      end else if (adv) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign mem_stall_o      = ~ex_flush_i & ~capture;
  assign mem_valid_o      = valid_q;
  assign mem_pc_o         = pc_q;
  assign mem_memadr_o     = adr_q;
  assign mem_misaligned_o = mis_q;
  assign dmem_req_o       = (state_q == REQ);
  assign dmem_we_o        = we_q;
  assign dmem_adr_o       = {adr_q[XLEN-1:2], 2'b00};
  assign dmem_be_o        = be_q;
  assign dmem_d_o         = d_q;
  assign outstanding_o    = cnt_q;

endmodule
